regfile_copy_engine: RTL



---
 rtl/regfile_copy_engine.sv | 124 ++++++++++++
 1 files changed

// File: rtl/regfile_copy_engine.sv
// Copies a block of words inside a single-port register file, one read and one write cycle per word.
// Optional running checksum of copied words: define REGFILE_COPY_CHECKSUM_EN.
module regfile_copy_engine #(
  parameter int unsigned ADDr_WIDTH = 10,
  parameter int unsigned mem_WIDTH  = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [ADDr_WIDTH-1:0]   src_addr,
  input  logic [ADDr_WIDTH-1:0]   dst_addr,
  input  logic [ADDr_WIDTH:0]     len,
  output logic                    busy,
  output logic                    done,
  output logic [ADDr_WIDTH-1:0]   ADDr,
  output logic                    rd_en,
  output logic                    wr_en,
  output logic [mem_WIDTH-1:0]    wr_DATA,
  input  logic [mem_WIDTH-1:0]    rd_DATA
`ifdef REGFILE_COPY_CHECKSUM_EN
  ,
  output logic [mem_WIDTH-1:0]    checksum
`endif
);

  localparam int unsigned AW = ADDr_WIDTH;
  localparam int unsigned CW = ADDr_WIDTH + 1;
  localparam int unsigned DW = mem_WIDTH;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RD   = 2'd1;
  localparam logic [1:0] WR   = 2'd2;
  localparam logic [1:0] DONE = 2'd3;

  logic [1:0]    state, state_n;
  logic [AW-1:0] src_ptr, src_ptr_n;
  logic [AW-1:0] dst_ptr, dst_ptr_n;
  logic [CW-1:0] remain, remain_n;
  logic          busy_n, done_n, rd_en_n, wr_en_n;
  logic [AW-1:0] addr_n;

  // Next state, pointers, and the port values the next state will present
  always_comb begin
    state_n   = state;
    src_ptr_n = src_ptr;
    dst_ptr_n = dst_ptr;
    remain_n  = remain;
    case (state)
      IDLE: begin
        if (start) begin
          src_ptr_n = src_addr;
          dst_ptr_n = dst_addr;
          remain_n  = len;
          state_n   = (len == CW'(0)) ? DONE : RD;
        end
      end
      RD: begin
        src_ptr_n = src_ptr + AW'(1);
        state_n   = WR;
      end
      WR: begin
        dst_ptr_n = dst_ptr + AW'(1);
        remain_n  = remain - CW'(1);
        state_n   = (remain == CW'(1)) ? DONE : RD;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase

    busy_n  = (state_n == RD) || (state_n == WR);
    done_n  = (state_n == DONE);
    rd_en_n = (state_n == RD);
    wr_en_n = (state_n == WR);
    addr_n  = '0;
    if (state_n == RD) addr_n = src_ptr_n;
    if (state_n == WR) addr_n = dst_ptr_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      src_ptr <= '0;
      dst_ptr <= '0;
      remain  <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      rd_en   <= 1'b0;
      wr_en   <= 1'b0;
      ADDr    <= '0;
    end else begin
      state   <= state_n;
      src_ptr <= src_ptr_n;
      dst_ptr <= dst_ptr_n;
      remain  <= remain_n;
      busy    <= busy_n;
      done    <= done_n;
      rd_en   <= rd_en_n;
      wr_en   <= wr_en_n;
      ADDr    <= addr_n;
    end
  end

  // Read data arrives in the WR cycle and is forwarded straight to the write port
  always_comb begin
    wr_DATA = '0;
    if (state == WR) wr_DATA = rd_DATA;
  end

`ifdef REGFILE_COPY_CHECKSUM_EN
  logic [DW-1:0] checksum_n;

  always_comb begin
    checksum_n = checksum;
    if ((state == IDLE) && start) checksum_n = '0;
    else if (state == WR)         checksum_n = checksum + rd_DATA;
  end

  always_ff @(posedge clk) begin
    if (rst) checksum <= '0;
    else     checksum <= checksum_n;
  end
`endif

endmodule
